captura_contagem: RTL and testbench

CAPTURA_CONTAGEM -- requirements
Module: captura_contagem

---
 rtl/captura_pkg.sv | 12 +
 rtl/fifo_sincrona.sv | 66 ++++++
 rtl/captura_contagem.sv | 86 ++++++++
 tb/tb_captura_contagem.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/captura_pkg.sv
// Shared widths and the FIFO entry layout for the count/timer capture block.
package captura_pkg;
  localparam int COUNT_W = 4;
  localparam int TIMER_W = 5;

  typedef struct packed {
    logic [TIMER_W-1:0] timer;
    logic [COUNT_W-1:0] count;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/fifo_sincrona.sv
// Show-ahead synchronous FIFO of entry_t; push/pop arrive already qualified.
module fifo_sincrona
  import captura_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   empty,
  output logic   full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; empty entries are masked downstream.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (occ_q == '0);
  assign full  = (occ_q == DEPTH_OCC);
endmodule

// File: rtl/captura_contagem.sv
// Captures {timer,count} into a FIFO whenever count changes; tracks drops.
// Optional macro CAPTURA_OVF_COUNT_EN enables the saturating dropped-event counter.
module captura_contagem
  import captura_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  input  logic [TIMER_W-1:0] timer,
  input  logic               clear,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] dout,
  output logic               valid,
  output logic               full,
  output logic               overflow,
  output logic [7:0]         ovf_count
);
  logic [COUNT_W-1:0] count_q;
  logic               overflow_q, overflow_d;
  logic               evt, push, pop, drop;
  logic               fifo_empty, fifo_full;
  entry_t             din, head;

  assign evt   = (count != count_q);
  assign valid = !fifo_empty;
  // A pop frees a slot on the same edge, so a full FIFO still accepts the push.
  assign pop   = rd_en && valid && !clear;
  assign push  = evt && (!fifo_full || pop) && !clear;
  assign drop  = evt && fifo_full && !pop && !clear;

  assign din.timer = timer;
  assign din.count = count;

  fifo_sincrona #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (clear)     overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count;
      overflow_q <= overflow_d;
    end
  end

`ifdef CAPTURA_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clear)                           ovf_cnt_d = '0;
    else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

  assign dout     = valid ? head : '0;
  assign full     = fifo_full;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_captura_contagem.sv
// Directed bench for captura_contagem with DEPTH=8 and hand-computed expectations.
module tb_captura_contagem;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count;
  logic [4:0] timer;
  logic       clear;
  logic       rd_en;
  logic [8:0] dout;
  logic       valid, full, overflow;
  logic [7:0] ovf_count;

  int vectors = 0;
  int miscompares = 0;

`ifdef CAPTURA_OVF_COUNT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  captura_contagem #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .timer     (timer),
    .clear     (clear),
    .rd_en     (rd_en),
    .dout      (dout),
    .valid     (valid),
    .full      (full),
    .overflow  (overflow),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ent(input int t, input int c);
    logic [4:0] tt;
    logic [3:0] cc;
    tt = t[4:0];
    cc = c[3:0];
    return {23'd0, tt, cc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; count = 4'd0; timer = 5'd0; clear = 1'b0; rd_en = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ovfcnt", 32'(ovf_count), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_valid", 32'(valid), 32'd0);

    // Three count steps, no reads
    count = 4'd1; timer = 5'd5; tick();
    check("s1_valid", 32'(valid), 32'd1);
    check("s1_dout", 32'(dout), ent(5, 1));
    count = 4'd2; timer = 5'd6; tick();
    count = 4'd3; timer = 5'd7; tick();
    check("s3_dout", 32'(dout), ent(5, 1));
    check("s3_full", 32'(full), 32'd0);
    timer = 5'd30; tick();
    check("timer_only_dout", 32'(dout), ent(5, 1));
    rd_en = 1'b1; tick();
    check("rd1_dout", 32'(dout), ent(6, 2));
    tick();
    check("rd2_dout", 32'(dout), ent(7, 3));
    tick();
    check("rd3_valid", 32'(valid), 32'd0);
    check("rd3_dout", 32'(dout), 32'd0);

    // Reads on an empty FIFO are ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_rd_valid", 32'(valid), 32'd0);
      check("empty_rd_dout", 32'(dout), 32'd0);
    end
    rd_en = 1'b0; count = 4'd4; timer = 5'd9; tick();
    check("after_empty_dout", 32'(dout), ent(9, 4));
    rd_en = 1'b1; tick();
    check("pop_single_valid", 32'(valid), 32'd0);

    // Push and pop together on empty: push wins
    count = 4'd5; timer = 5'd10; tick();
    check("empty_pushpop_valid", 32'(valid), 32'd1);
    check("empty_pushpop_dout", 32'(dout), ent(10, 5));
    tick();
    check("empty_pushpop_drain", 32'(valid), 32'd0);
    rd_en = 1'b0;

    // Fill to DEPTH with counts 6..13
    for (int c = 6; c <= 13; c++) begin
      count = 4'(c); timer = 5'(c + 1); tick();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    check("fill_head", 32'(dout), ent(7, 6));

    // Push and pop together while full
    count = 4'd14; timer = 5'd20; rd_en = 1'b1; tick();
    rd_en = 1'b0;
    check("full_pushpop_full", 32'(full), 32'd1);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    check("full_pushpop_head", 32'(dout), ent(8, 7));

    // Two drops while full
    count = 4'd15; timer = 5'd21; tick();
    check("drop1_ovf", 32'(overflow), 32'd1);
    check("drop1_cnt", 32'(ovf_count), 32'(OVF_EN));
    count = 4'd0; timer = 5'd22; tick();
    check("drop2_full", 32'(full), 32'd1);
    check("drop2_cnt", 32'(ovf_count), 32'(2 * OVF_EN));

    // Drain and confirm contents, newest at tail
    rd_en = 1'b1;
    for (int c = 7; c <= 13; c++) begin
      check("drain_dout", 32'(dout), ent(c + 1, c));
      tick();
    end
    check("drain_tail", 32'(dout), ent(20, 14));
    tick();
    rd_en = 1'b0;
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Clear coincident with event and read
    count = 4'd1; timer = 5'd2; tick();
    count = 4'd2; timer = 5'd3; tick();
    check("pre_clear_valid", 32'(valid), 32'd1);
    clear = 1'b1; rd_en = 1'b1; count = 4'd3; timer = 5'd4; tick();
    clear = 1'b0; rd_en = 1'b0;
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(ovf_count), 32'd0);
    check("clr_dout", 32'(dout), 32'd0);
    tick();
    check("clr_countq_upd", 32'(valid), 32'd0);
    count = 4'd4; timer = 5'd5; tick();
    check("post_clr_dout", 32'(dout), ent(5, 4));

    // Four entries, then reset pulse with count=9 held
    count = 4'd5; timer = 5'd6; tick();
    count = 4'd6; timer = 5'd7; tick();
    count = 4'd7; timer = 5'd8; tick();
    count = 4'd9; timer = 5'd11; reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_dout", 32'(dout), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(valid), 32'd1);
    check("post_rst_dout", 32'(dout), ent(11, 9));
    rd_en = 1'b1; tick();
    rd_en = 1'b0;
    check("post_rst_single", 32'(valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
